// File: rtl/fifo_drain_reader_if.sv
// Valid/ready word stream from the FIFO drain reader to downstream logic.
// Optional parity wire present when FIFO_RD_PARITY_EN is defined.
interface fifo_drain_reader_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
`ifdef FIFO_RD_PARITY_EN
  logic             par;

  modport master (output data, output valid, output par, input ready);
  modport slave  (input data, input valid, input par, output ready);
`else
  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
`endif
endinterface

// File: rtl/fifo_drain_reader.sv
// Drains the synchronous FIFO into a 2-entry buffer that hides its read latency and streams
// words out on valid/ready. Optional per-entry parity via FIFO_RD_PARITY_EN.
module fifo_drain_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                fifo_empty,
  input  logic [WIDTH-1:0]    fifo_dout,
  output logic                fifo_rd,
  fifo_drain_reader_if.master out,
  output logic                busy,
  output logic [CNT_W-1:0]    word_cnt
);

  logic [WIDTH-1:0] mem_q [2];
  logic [1:0]       occ_q, occ_d;
  logic             head_q, head_d;
  logic             inflight_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pop;
  logic             wr_idx;
  logic [2:0]       pending;

  assign pop = out.valid && out.ready;

  // Buffer slots still claimed next cycle; an in-flight word already owns one.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd = !rst && en && !fifo_empty && (pending < 3'd2);

  // Occupancy plus in-flight never exceeds 2, so a capture only meets occupancy 0 or 1.
  assign wr_idx = head_q ^ occ_q[0];

  always_comb begin
    occ_d  = pending[1:0];
    head_d = head_q ^ pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      occ_q      <= '0;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= fifo_rd;
      occ_q      <= occ_d;
      head_q     <= head_d;
      if (inflight_q) begin
        mem_q[wr_idx] <= fifo_dout;
      end
      if (pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef FIFO_RD_PARITY_EN
  logic par_q [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q[0] <= 1'b0;
      par_q[1] <= 1'b0;
    end else if (inflight_q) begin
      par_q[wr_idx] <= ^fifo_dout;
    end
  end

  always_comb begin
    out.par = par_q[head_q];
  end
`endif

  always_comb begin
    out.valid = (occ_q != 2'd0);
    out.data  = mem_q[head_q];
    busy      = inflight_q || (occ_q != 2'd0);
    word_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Self-checking bench for fifo_drain_reader: behavioural FIFO, queue-based reference model,
// directed scenarios then randomized traffic with occasional asynchronous resets.
module tb_fifo_drain_reader;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SRC_N = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             fifo_empty;
  logic             fifo_rd;
  logic             busy;
  logic [WIDTH-1:0] fifo_dout;
  logic [CNT_W-1:0] word_cnt;

  fifo_drain_reader_if #(.WIDTH(WIDTH)) sif ();

  fifo_drain_reader #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .out        (sif.master),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  // Behavioural FIFO: words src[rd_ptr .. avail-1] are stored.
  logic [WIDTH-1:0] src [SRC_N];
  int unsigned      avail, rd_ptr, n_rd;
  int unsigned      n_checks, n_errors;

  // Reference model: words returned from the FIFO and not yet delivered, plus one in flight.
  logic [WIDTH-1:0] mbuf [$];
  bit               m_infl;
  logic [WIDTH-1:0] m_infl_word;
  int unsigned      m_ptr, m_cnt;

  assign fifo_empty = (rd_ptr >= avail);

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] word);
    src[avail] = word;
    avail++;
  endtask

  task automatic model_reset();
    mbuf.delete();
    m_infl = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock cycle, entered and left at a falling edge with inputs already applied.
  task automatic step();
    bit               m_valid, m_pop, m_rd, rd_seen;
    logic [WIDTH-1:0] m_data;
    #1;
    m_valid = (mbuf.size() != 0);
    m_data  = m_valid ? mbuf[0] : '0;
    m_pop   = m_valid && sif.ready;
    m_rd    = en && (m_ptr < avail) &&
              ((int'(mbuf.size()) + int'(m_infl) - int'(m_pop)) < 2);
    check_eq("fifo_rd", fifo_rd, m_rd);
    check_eq("out_valid", sif.valid, m_valid);
    if (m_valid) check_eq("out_data", sif.data, m_data);
    check_eq("busy", busy, m_infl || m_valid);
    check_eq("word_cnt", word_cnt, m_cnt);
`ifdef FIFO_RD_PARITY_EN
    if (m_valid) check_eq("out_par", sif.par, ^m_data);
`endif
    rd_seen = fifo_rd;
    @(posedge clk);
    if (m_pop) begin
      void'(mbuf.pop_front());
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    if (m_infl) mbuf.push_back(m_infl_word);
    m_infl = m_rd;
    if (m_rd) begin
      m_infl_word = src[m_ptr];
      m_ptr++;
    end
    @(negedge clk);
    if (rd_seen) begin
      fifo_dout = src[rd_ptr];
      rd_ptr++;
      n_rd++;
    end else begin
      fifo_dout = WIDTH'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts rst between edges and checks that outputs clear without waiting for a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_valid", sif.valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cnt", word_cnt, 0);
    check_eq("rst_rd", fifo_rd, 0);
    check_eq("rst_data", sif.data, 0);
`ifdef FIFO_RD_PARITY_EN
    check_eq("rst_par", sif.par, 0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    fifo_dout = WIDTH'($urandom);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned      n0, c0;
    logic [WIDTH-1:0] exp_next;
    rst = 1'b1; en = 1'b0; sif.ready = 1'b0; fifo_dout = '0;
    avail = 0; rd_ptr = 0; n_rd = 0; n_checks = 0; n_errors = 0;
    m_ptr = 0;
    model_reset();
    for (int i = 0; i < SRC_N; i++) src[i] = WIDTH'($urandom);

    @(negedge clk);
    #1;
    check_eq("init_valid", sif.valid, 0);
    check_eq("init_data", sif.data, 0);
    check_eq("init_busy", busy, 0);
    check_eq("init_cnt", word_cnt, 0);
    check_eq("init_rd", fifo_rd, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stream of three words at full rate
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1; sif.ready = 1'b1;
    n0 = n_rd;
    run(6);
    check_eq("stream_reads", n_rd - n0, 3);
    check_eq("stream_cnt", word_cnt, 3);
    check_eq("stream_busy", busy, 0);

    // Backpressure: only two words may leave the FIFO
    sif.ready = 1'b0;
    for (int i = 0; i < 5; i++) push(WIDTH'(8'hA0 + i));
    n0 = n_rd;
    run(6);
    check_eq("bp_reads", n_rd - n0, 2);
    check_eq("bp_valid", sif.valid, 1);
    check_eq("bp_head", sif.data, 8'hA0);
    sif.ready = 1'b1;
    run(8);
    check_eq("bp_cnt", word_cnt, 8);

    // Empty FIFO, then a single word
    n0 = n_rd;
    run(10);
    check_eq("empty_reads", n_rd - n0, 0);
    push(8'h5A);
    run(4);
    check_eq("single_reads", n_rd - n0, 1);

    // en drops the cycle after a read
    for (int i = 0; i < 4; i++) push(WIDTH'(8'hC0 + i));
    n0 = n_rd; c0 = word_cnt;
    run(1);
    en = 1'b0;
    run(6);
    check_eq("endrop_reads", n_rd - n0, 1);
    check_eq("endrop_cnt", word_cnt, (c0 + 1) % 16);

    // Asynchronous reset with the buffer full
    en = 1'b1; sif.ready = 1'b0;
    run(4);
    check_eq("pre_rst_valid", sif.valid, 1);
    exp_next = src[rd_ptr];
    async_reset();
    sif.ready = 1'b1;
    for (int i = 0; i < 10 && !sif.valid; i++) step();
    check_eq("post_rst_valid", sif.valid, 1);
    check_eq("post_rst_word", sif.data, exp_next);
    run(4);

    // Counter wrap: 17 words on a 4-bit counter
    async_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 5) push(8'h07);
      else if (i == 6) push(8'h03);
      else push(WIDTH'($urandom));
    end
    run(25);
    check_eq("wrap_cnt", word_cnt, 1);
    check_eq("wrap_busy", busy, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      sif.ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) push(WIDTH'($urandom));
      if ($urandom_range(0, 5) == 0) push(WIDTH'($urandom));
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end
    en = 1'b1; sif.ready = 1'b1;
    for (int i = 0; i < 3000 && (rd_ptr < avail || busy); i++) step();
    check_eq("drain_all_read", rd_ptr, avail);
    check_eq("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
